pic_mem_port_arbiter: RTL and testbench
=======================================

// Module: pic_mem_port_arbiter
// PURPOSE
// - Shares one on-chip RAM s2 slave port (pic_mem / background_mem style) between two requesters.
//   - Port A: PIC32 SPI link writer.
//   - Port B: LCD pixel fetch / NIOS-side helper.
// - Round-robin arbitration with a bounded burst length.
// - Registers every memory-side output.
// - Returns read data to the owning requester, tagged through the RAM read pipeline.
// PARAMETERS
// - ADDR_W     12  RAM word address width (13 for background_mem).
// - DATA_W     16  RAM data width; byteenable width is DATA_W/8.
// - RD_LAT     1   RAM readdata latency in cycles after address is presented (1 or 2).
// - MAX_BURST  8   Max consecutive grants to one requester while the other is requesting (>=1).
// PORTS
// - clk             in   1         system clock, rising edge.
// - reset           in   1         synchronous, active-high reset.
// - a_req           in   1         A request valid; a_we/a_addr/a_wdata/a_be stable until a_gnt.
// - a_we            in   1         1=write, 0=read.
// - a_addr          in   ADDR_W    A word address.
// - a_wdata         in   DATA_W    A write data.
// - a_be            in   DATA_W/8  A byte enables.
// - a_gnt           out  1         request accepted this cycle (combinational).
// - a_rvalid        out  1         one-cycle pulse, a_rdata valid.
// - a_rdata         out  DATA_W    read data for A.
// - b_*             -    -         identical set for requester B.
// - mem_address     out  ADDR_W    to RAM s2 address.
// - mem_chipselect  out  1         to RAM s2 chipselect.
// - mem_clken       out  1         to RAM s2 clken.
// - mem_write       out  1         to RAM s2 write.
// - mem_writedata   out  DATA_W    to RAM s2 writedata.
// - mem_byteenable  out  DATA_W/8  to RAM s2 byteenable.
// - mem_readdata    in   DATA_W    from RAM s2 readdata.
// BEHAVIOUR
// - Reset values: all outputs 0; owner=NONE; priority=A; burst count=0; tag pipe cleared.
// - FSM owner states:
//   - IDLE.
//   - OWN_A, OWN_B: the last grant went to that requester.
// - Per-cycle arbitration:
//   - Exactly one requester asserting req is granted.
//   - Both asserting:
//     - Current owner keeps the grant while burst_cnt < MAX_BURST.
//     - Otherwise the other requester is granted.
//     - From IDLE, the priority pointer (the one not served last; A after reset) wins.
//   - Neither asserting: FSM goes to IDLE. burst_cnt is cleared; the priority pointer is kept.
// - burst_cnt behaviour:
//   - Increments on each grant to the current owner.
//   - Loads 1 on an owner change.
//   - Saturates at MAX_BURST.
//   - A lone requester is granted every cycle regardless of burst_cnt.
// - At most one gnt per cycle.
// - gnt = req & selected, combinational from the registered FSM state. A requester may drop req without a gnt.
// - Issue stage: on grant in cycle t, registered at edge t+1:
//   - mem_address, mem_write, mem_writedata and mem_byteenable take the granted request's values.
//   - mem_chipselect=1.
//   - No grant in cycle t: mem_chipselect=0 and mem_write=0 in t+1; address/data hold their last values.
// - mem_clken = 1 in every cycle after reset; 0 during reset.
// - Read return:
//   - A tag {valid, owner} enters an RD_LAT-deep shift register when a read issues.
//   - x_rvalid pulses and x_rdata = mem_readdata exactly RD_LAT cycles after mem_chipselect/address.
//   - Gnt-to-rvalid latency = 1+RD_LAT cycles.
//   - x_rdata holds its value between pulses.
// - Writes produce no rvalid. be=0 writes are still issued; the RAM ignores them.
// - Back-to-back reads from both requesters interleave at one per cycle. Return order = issue order.
// - A write followed by a read to the same address on consecutive grants returns the new data.
// - Reset mid-operation: tag pipe is flushed, so in-flight reads never return rvalid. mem_* returns to 0 on the next edge.
// TESTING
// - Reset:
//   - Hold reset 3 cycles with a_req=b_req=1 -> all outputs 0, no gnt.
//   - Release -> a_gnt first.
// - Lone A reads, RD_LAT=1:
//   - a_req held, addr 0x010..0x013 -> a_gnt on 4 consecutive cycles.
//   - mem_chipselect 1 cycle later.
//   - a_rvalid 2 cycles after each gnt, data = RAM model contents.
// - Contention, MAX_BURST=8:
//   - Both req held continuously -> grant pattern A x8, B x8, A x8.
//   - No cycle has both gnts.
// - Write/read coherency:
//   - B writes 0xBEEF (be=11) to 0x055, then A reads 0x055 next cycle -> a_rdata=0xBEEF.
//   - b_rvalid never asserted.
// - Byte enables: write 0x1234 to 0x007, then write 0xAB00 be=10 -> readback 0xAB34.
// - Reset mid-read:
//   - Issue A read, assert reset the following cycle -> no a_rvalid.
//   - After release, normal operation resumes with A priority.

Source files
------------

// File: rtl/pic_mem_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: one request/grant handshake
// plus the tagged read-return path for that requester.
interface pic_mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/pic_mem_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one RAM s2 port between two
// requesters; memory outputs are registered and read data is routed back by tag.
module pic_mem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    pic_mem_port_arbiter_if.slave a_if,
    pic_mem_port_arbiter_if.slave b_if,
    output logic [ADDR_W-1:0]     mem_address_o,
    output logic                  mem_chipselect_o,
    output logic                  mem_clken_o,
    output logic                  mem_write_o,
    output logic [DATA_W-1:0]     mem_writedata_o,
    output logic [DATA_W/8-1:0]   mem_byteenable_o,
    input  logic [DATA_W-1:0]     mem_readdata_i
);
    localparam int BE_W = DATA_W / 8;
    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
    localparam logic [BC_W-1:0] BURST_ONE = BC_W'(1);

    logic [1:0]        state_q, state_d;
    logic              prio_b_q, prio_b_d;
    logic [BC_W-1:0]   burst_q, burst_d;

    logic              sel_a_s, sel_b_s, gnt_any_s;
    logic              iss_we_s;
    logic [ADDR_W-1:0] iss_addr_s;
    logic [DATA_W-1:0] iss_wdata_s;
    logic [BE_W-1:0]   iss_be_s;

    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_chipselect_q, mem_clken_q, mem_write_q;
    logic [DATA_W-1:0] mem_writedata_q;
    logic [BE_W-1:0]   mem_byteenable_q;

    logic              rd_issue_q, rd_own_b_q;
    logic [RD_LAT-1:0] tag_vld_q, tag_own_q;
    logic [RD_LAT:0]   tag_vld_s, tag_own_s;
    logic              rvalid_a_s, rvalid_b_s;
    logic [DATA_W-1:0] hold_a_q, hold_b_q;

    // Grant selection from the registered owner state; nothing is granted while in reset.
    always_comb begin
        sel_a_s = 1'b0;
        sel_b_s = 1'b0;
        if (reset_i) begin
            sel_a_s = 1'b0;
            sel_b_s = 1'b0;
        end else if (a_if.req && b_if.req) begin
            case (state_q)
                ST_OWN_A: begin
                    if (burst_q < BURST_MAX) sel_a_s = 1'b1;
                    else                     sel_b_s = 1'b1;
                end
                ST_OWN_B: begin
                    if (burst_q < BURST_MAX) sel_b_s = 1'b1;
                    else                     sel_a_s = 1'b1;
                end
                default: begin
                    if (prio_b_q) sel_b_s = 1'b1;
                    else          sel_a_s = 1'b1;
                end
            endcase
        end else if (a_if.req) begin
            sel_a_s = 1'b1;
        end else if (b_if.req) begin
            sel_b_s = 1'b1;
        end else begin
            sel_a_s = 1'b0;
            sel_b_s = 1'b0;
        end
    end

    assign gnt_any_s = sel_a_s | sel_b_s;
    assign a_if.gnt  = sel_a_s;
    assign b_if.gnt  = sel_b_s;

    // Owner, priority pointer and saturating burst count for the next cycle.
    always_comb begin
        state_d  = state_q;
        prio_b_d = prio_b_q;
        burst_d  = burst_q;
        if (sel_a_s) begin
            state_d  = ST_OWN_A;
            prio_b_d = 1'b1;
            if (state_q != ST_OWN_A)     burst_d = BURST_ONE;
            else if (burst_q == BURST_MAX) burst_d = BURST_MAX;
            else                         burst_d = burst_q + BURST_ONE;
        end else if (sel_b_s) begin
            state_d  = ST_OWN_B;
            prio_b_d = 1'b0;
            if (state_q != ST_OWN_B)     burst_d = BURST_ONE;
            else if (burst_q == BURST_MAX) burst_d = BURST_MAX;
            else                         burst_d = burst_q + BURST_ONE;
        end else begin
            state_d = ST_IDLE;
            burst_d = '0;
        end
    end

    // Mux of the granted request; address/data hold when nothing is granted.
    always_comb begin
        iss_we_s    = 1'b0;
        iss_addr_s  = mem_address_q;
        iss_wdata_s = mem_writedata_q;
        iss_be_s    = mem_byteenable_q;
        if (sel_a_s) begin
            iss_we_s    = a_if.we;
            iss_addr_s  = a_if.addr;
            iss_wdata_s = a_if.wdata;
            iss_be_s    = a_if.be;
        end else if (sel_b_s) begin
            iss_we_s    = b_if.we;
            iss_addr_s  = b_if.addr;
            iss_wdata_s = b_if.wdata;
            iss_be_s    = b_if.be;
        end else begin
            iss_we_s = 1'b0;
        end
    end

    // The issue-stage read tag is stage 0; RD_LAT further stages line it up with readdata.
    assign tag_vld_s  = {tag_vld_q, rd_issue_q};
    assign tag_own_s  = {tag_own_q, rd_own_b_q};
    assign rvalid_a_s = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign rvalid_b_s = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];

    // Arbitration state, registered memory port and read-tag pipeline.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            prio_b_q         <= 1'b0;
            burst_q          <= '0;
            mem_address_q    <= '0;
            mem_chipselect_q <= 1'b0;
            mem_clken_q      <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            rd_issue_q       <= 1'b0;
            rd_own_b_q       <= 1'b0;
            tag_vld_q        <= '0;
            tag_own_q        <= '0;
        end else begin
            state_q          <= state_d;
            prio_b_q         <= prio_b_d;
            burst_q          <= burst_d;
            mem_address_q    <= iss_addr_s;
            mem_chipselect_q <= gnt_any_s;
            mem_clken_q      <= 1'b1;
            mem_write_q      <= iss_we_s;
            mem_writedata_q  <= iss_wdata_s;
            mem_byteenable_q <= iss_be_s;
            rd_issue_q       <= gnt_any_s & ~iss_we_s;
            rd_own_b_q       <= sel_b_s;
            tag_vld_q        <= tag_vld_s[RD_LAT-1:0];
            tag_own_q        <= tag_own_s[RD_LAT-1:0];
        end
    end

    // Last returned word per requester, so rdata stays stable between pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else begin
            if (rvalid_a_s) hold_a_q <= mem_readdata_i;
            if (rvalid_b_s) hold_b_q <= mem_readdata_i;
        end
    end

    assign a_if.rvalid = rvalid_a_s;
    assign b_if.rvalid = rvalid_b_s;
    assign a_if.rdata  = rvalid_a_s ? mem_readdata_i : hold_a_q;
    assign b_if.rdata  = rvalid_b_s ? mem_readdata_i : hold_b_q;

    assign mem_address_o    = mem_address_q;
    assign mem_chipselect_o = mem_chipselect_q;
    assign mem_clken_o      = mem_clken_q;
    assign mem_write_o      = mem_write_q;
    assign mem_writedata_o  = mem_writedata_q;
    assign mem_byteenable_o = mem_byteenable_q;
endmodule

// File: tb/tb_pic_mem_port_arbiter.sv
// Directed bench for pic_mem_port_arbiter: arbitration vector table plus
// hand-written read-return, coherency, byte-enable and reset sequences.
module tb_pic_mem_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pic_mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    pic_mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_clken, mem_write;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic [BE_W-1:0]   mem_byteenable;

    pic_mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .MAX_BURST(8)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .a_if             (a_if),
        .b_if             (b_if),
        .mem_address_o    (mem_address),
        .mem_chipselect_o (mem_chipselect),
        .mem_clken_o      (mem_clken),
        .mem_write_o      (mem_write),
        .mem_writedata_o  (mem_writedata),
        .mem_byteenable_o (mem_byteenable),
        .mem_readdata_i   (mem_readdata)
    );

    // RAM model: one-cycle read latency, byte-lane writes, known pattern loaded in reset.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_rd_q;
    assign mem_readdata = ram_rd_q;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= {4'hC, 12'(i)};
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end else begin
                ram_rd_q <= ram[mem_address];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
        a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wd; a_if.be = be;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
        b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wd; b_if.be = be;
    endtask

    typedef struct packed {
        logic a_req;
        logic b_req;
        logic exp_a;
        logic exp_b;
    } vec_t;

    vec_t tab [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Arbitration table; starts from IDLE with the pointer at B, ends IDLE with pointer at A.
        tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tab[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        tab[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with both requesting
        reset = 1'b1;
        drive_a(1'b1, 1'b1, 12'h3A0, 16'h0000, 2'b00);
        drive_b(1'b1, 1'b1, 12'h3B0, 16'h0000, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("rst_a_gnt", a_if.gnt, 32'd0);
            chk("rst_b_gnt", b_if.gnt, 32'd0);
            chk("rst_cs", mem_chipselect, 32'd0);
            chk("rst_clken", mem_clken, 32'd0);
            chk("rst_write", mem_write, 32'd0);
            chk("rst_addr", mem_address, 32'd0);
            chk("rst_a_rvalid", a_if.rvalid, 32'd0);
            chk("rst_b_rvalid", b_if.rvalid, 32'd0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rel_a_gnt", a_if.gnt, 32'd1);
        chk("rel_b_gnt", b_if.gnt, 32'd0);
        tick();
        drive_a(1'b0, 1'b0, 12'h000, 16'h0000, 2'b00);
        drive_b(1'b0, 1'b0, 12'h000, 16'h0000, 2'b00);
        @(negedge clk);
        chk("rel_clken", mem_clken, 32'd1);
        chk("rel_cs", mem_chipselect, 32'd1);
        chk("rel_write", mem_write, 32'd1);
        chk("rel_addr", mem_address, 32'h3A0);
        tick();

        // Lone A reads of 0x010..0x013
        for (int j = 0; j < 7; j++) begin
            if (j > 0) tick();
            drive_a(j < 4, 1'b0, 12'(12'h010 + j), 16'h0000, 2'b11);
            @(negedge clk);
            chk("lone_a_gnt", a_if.gnt, 32'(j < 4));
            chk("lone_cs", mem_chipselect, 32'(j >= 1 && j <= 4));
            chk("lone_a_rvalid", a_if.rvalid, 32'(j >= 2 && j <= 5));
            chk("lone_b_rvalid", b_if.rvalid, 32'd0);
            if (j >= 2 && j <= 5) chk("lone_a_rdata", a_if.rdata, 32'(16'hC010 + j - 2));
            else if (j == 6)      chk("lone_a_rdata_hold", a_if.rdata, 32'hC013);
        end
        tick();

        // Table-driven arbitration with be=0 writes
        for (int i = 0; i < 11; i++) begin
            drive_a(tab[i].a_req, 1'b1, 12'(12'h100 + i), 16'h5555, 2'b00);
            drive_b(tab[i].b_req, 1'b1, 12'(12'h200 + i), 16'hAAAA, 2'b00);
            @(negedge clk);
            chk("tab_a_gnt", a_if.gnt, 32'(tab[i].exp_a));
            chk("tab_b_gnt", b_if.gnt, 32'(tab[i].exp_b));
            tick();
            chk("tab_cs", mem_chipselect, 32'(tab[i].exp_a | tab[i].exp_b));
            chk("tab_write", mem_write, 32'(tab[i].exp_a | tab[i].exp_b));
            if (tab[i].exp_a) chk("tab_addr_a", mem_address, 32'(12'h100 + i));
            if (tab[i].exp_b) chk("tab_addr_b", mem_address, 32'(12'h200 + i));
        end

        // Sustained contention, then lone A past the burst limit, then contention again
        for (int i = 0; i < 27; i++) begin
            drive_a(1'b1, 1'b1, 12'h300, 16'h0000, 2'b00);
            drive_b(!(i == 24 || i == 25), 1'b1, 12'h301, 16'h0000, 2'b00);
            @(negedge clk);
            chk("cont_a_gnt", a_if.gnt, 32'((i < 8) || (i >= 16 && i < 26)));
            chk("cont_b_gnt", b_if.gnt, 32'((i >= 8 && i < 16) || i == 26));
            chk("cont_both_gnt", a_if.gnt & b_if.gnt, 32'd0);
            tick();
        end
        drive_a(1'b0, 1'b0, 12'h000, 16'h0000, 2'b00);
        drive_b(1'b0, 1'b0, 12'h000, 16'h0000, 2'b00);
        tick();

        // B writes 0xBEEF to 0x055, A reads it on the next grant
        for (int j = 0; j < 6; j++) begin
            if (j > 0) tick();
            drive_b(j == 0, 1'b1, 12'h055, 16'hBEEF, 2'b11);
            drive_a(j == 1, 1'b0, 12'h055, 16'h0000, 2'b11);
            @(negedge clk);
            if (j == 0) chk("coh_b_gnt", b_if.gnt, 32'd1);
            if (j == 1) chk("coh_a_gnt", a_if.gnt, 32'd1);
            chk("coh_b_rvalid", b_if.rvalid, 32'd0);
            chk("coh_a_rvalid", a_if.rvalid, 32'(j == 3));
            if (j == 3) chk("coh_a_rdata", a_if.rdata, 32'hBEEF);
        end
        tick();

        // Byte-lane merge: 0x1234 then 0xAB00 with upper lane only
        for (int j = 0; j < 6; j++) begin
            if (j > 0) tick();
            case (j)
                0:       drive_a(1'b1, 1'b1, 12'h007, 16'h1234, 2'b11);
                1:       drive_a(1'b1, 1'b1, 12'h007, 16'hAB00, 2'b10);
                2:       drive_a(1'b1, 1'b0, 12'h007, 16'h0000, 2'b11);
                default: drive_a(1'b0, 1'b0, 12'h007, 16'h0000, 2'b00);
            endcase
            @(negedge clk);
            chk("be_a_gnt", a_if.gnt, 32'(j < 3));
            chk("be_a_rvalid", a_if.rvalid, 32'(j == 4));
            if (j == 4) chk("be_a_rdata", a_if.rdata, 32'hAB34);
        end
        tick();

        // Reset one cycle after an A read issues; then interleaved A/B reads
        for (int j = 0; j < 7; j++) begin
            if (j > 0) tick();
            reset = (j == 1 || j == 2);
            drive_a(j == 0 || j == 3, 1'b0, (j == 0) ? 12'h010 : 12'h011, 16'h0000, 2'b11);
            drive_b(j == 3 || j == 4, 1'b0, 12'h012, 16'h0000, 2'b11);
            @(negedge clk);
            chk("mr_a_gnt", a_if.gnt, 32'(j == 0 || j == 3));
            chk("mr_b_gnt", b_if.gnt, 32'(j == 4));
            chk("mr_a_rvalid", a_if.rvalid, 32'(j == 5));
            chk("mr_b_rvalid", b_if.rvalid, 32'(j == 6));
            if (j == 2) begin
                chk("mr_cs_flushed", mem_chipselect, 32'd0);
                chk("mr_clken_rst", mem_clken, 32'd0);
            end
            if (j == 4) chk("mr_clken_run", mem_clken, 32'd1);
            if (j == 5) chk("mr_a_rdata", a_if.rdata, 32'hC011);
            if (j == 6) chk("mr_b_rdata", b_if.rdata, 32'hC012);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
